// File: rtl/sec_corrector_keyed.sv
// Pipelined single-error-correcting (Hamming) data corrector with key-based logic locking.
// Data sits on the non-power-of-2 Hamming positions 1..DATA_W+CHK_W, LSB first.
// Output data stays XOR-masked until the correct key has been shifted in serially.
//
// Ports:
//   clk_i, rst_i              clock (rising edge), asynchronous active-high reset
//   in_valid_i / in_ready_o   input stream handshake
//   in_data_i, in_chk_i       received data and check bits
//   corr_en_i                 1: correct, 0: bypass (syndrome forced to zero)
//   out_valid_o / out_ready_i output stream handshake
//   out_data_o                corrected (and, while locked, masked) data
//   out_corr_o                a data bit was flipped
//   out_chk_err_o             syndrome is a power of 2 (check-bit error)
//   out_uncorr_o              syndrome points beyond the codeword
//   key_load_i                start a key load (clears the bit counter)
//   key_vld_i, key_bit_i      serial key bit, MSB first
//   locked_o                  1 unless the correct key is loaded and no load is in progress
module sec_corrector_keyed #(
  parameter int unsigned         DATA_W    = 32,
  parameter int unsigned         CHK_W     = 6,
  parameter int unsigned         KEY_W     = 104,
  parameter logic [KEY_W-1:0]    KEY_VALUE = 104'hA5C3_0F96_3C5A_E1D2_7B48_96F0_1E
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CHK_W-1:0]  in_chk_i,
  input  logic              corr_en_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_corr_o,
  output logic              out_chk_err_o,
  output logic              out_uncorr_o,
  input  logic              key_load_i,
  input  logic              key_vld_i,
  input  logic              key_bit_i,
  output logic              locked_o
);

  localparam int unsigned NPos    = DATA_W + CHK_W;
  localparam int unsigned NChunks = (KEY_W + DATA_W - 1) / DATA_W;
  localparam int unsigned PadW    = NChunks * DATA_W;
  localparam int unsigned CntW    = $clog2(KEY_W + 1);

  function automatic logic is_pow2(int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Hamming position of data bit idx.
  function automatic int unsigned data_pos(int unsigned idx);
    int unsigned n;
    int unsigned res;
    n   = 0;
    res = 0;
    for (int unsigned p = 1; p <= NPos; p++) begin
      if (!is_pow2(p)) begin
        if (n == idx) res = p;
        n++;
      end
    end
    return res;
  endfunction

  // Data bits that contribute to check bit i.
  function automatic logic [DATA_W-1:0] col_mask(int unsigned i);
    logic [DATA_W-1:0] m;
    int unsigned       n;
    m = '0;
    n = 0;
    for (int unsigned p = 1; p <= NPos; p++) begin
      if (!is_pow2(p)) begin
        if (n < DATA_W && p[i]) m[n] = 1'b1;
        n++;
      end
    end
    return m;
  endfunction

  // XOR of DATA_W-bit chunks of k; the top chunk is zero-padded.
  function automatic logic [DATA_W-1:0] fold_key(logic [KEY_W-1:0] k);
    logic [PadW-1:0]   padded;
    logic [DATA_W-1:0] r;
    padded = PadW'(k);
    r      = '0;
    for (int unsigned c = 0; c < NChunks; c++) begin
      r ^= padded[c*DATA_W +: DATA_W];
    end
    return r;
  endfunction

  // key_reg resets to zero, so the reset mask is the fold of the key itself.
  localparam logic [DATA_W-1:0] ResetMask = fold_key(KEY_VALUE);

  typedef enum logic [1:0] {StLocked, StLoad, StUnlocked} key_state_e;

  key_state_e        state_q;
  logic [KEY_W-1:0]  key_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] mask_q;
  logic              locked_q;

  logic              v1_q, v2_q;
  logic [DATA_W-1:0] data1_q;
  logic [CHK_W-1:0]  syn1_q;
  logic [DATA_W-1:0] out_data_q;
  logic              corr_q, chk_err_q, uncorr_q;

  logic              s1_rdy, s2_rdy, accept;
  logic [CHK_W-1:0]  chk_calc;
  logic [CHK_W-1:0]  syn_d;
  logic [DATA_W-1:0] flip;
  logic [KEY_W-1:0]  key_shift;
  logic              key_match;

  // ---------------------------------------------------------------------------
  // Syndrome and correction vector
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < CHK_W; i++) begin : g_chk
    localparam logic [DATA_W-1:0] ColMask = col_mask(i);
    assign chk_calc[i] = ^(in_data_i & ColMask);
  end

  assign syn_d = corr_en_i ? (chk_calc ^ in_chk_i) : '0;

  // Only non-power-of-2 positions within the codeword can match, so check-bit
  // errors and out-of-range syndromes leave the data untouched.
  for (genvar j = 0; j < DATA_W; j++) begin : g_flip
    localparam logic [CHK_W-1:0] PosJ = CHK_W'(data_pos(j));
    assign flip[j] = (syn1_q == PosJ);
  end

  // ---------------------------------------------------------------------------
  // Stream control
  // ---------------------------------------------------------------------------
  assign s2_rdy     = !v2_q || out_ready_i;
  assign s1_rdy     = !v1_q || s2_rdy;
  assign in_ready_o = s1_rdy && (state_q != StLoad);
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q    <= 1'b0;
      data1_q <= '0;
      syn1_q  <= '0;
    end else if (s1_rdy) begin
      v1_q <= accept;
      if (accept) begin
        data1_q <= in_data_i;
        syn1_q  <= syn_d;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v2_q       <= 1'b0;
      out_data_q <= '0;
      corr_q     <= 1'b0;
      chk_err_q  <= 1'b0;
      uncorr_q   <= 1'b0;
    end else if (s2_rdy) begin
      v2_q <= v1_q;
      if (v1_q) begin
        // Mask is taken at S2 load, so words in flight during a key load
        // still see the pre-load mask.
        out_data_q <= (data1_q ^ flip) ^ ((state_q == StUnlocked) ? '0 : mask_q);
        corr_q     <= |flip;
        chk_err_q  <= is_pow2(32'(syn1_q));
        uncorr_q   <= 32'(syn1_q) > NPos;
      end
    end
  end

  assign out_valid_o   = v2_q;
  assign out_data_o    = out_data_q;
  assign out_corr_o    = corr_q;
  assign out_chk_err_o = chk_err_q;
  assign out_uncorr_o  = uncorr_q;

  // ---------------------------------------------------------------------------
  // Key FSM
  // ---------------------------------------------------------------------------
  assign key_shift = {key_q[KEY_W-2:0], key_bit_i};
  assign key_match = (key_shift == KEY_VALUE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StLocked;
      key_q    <= '0;
      cnt_q    <= '0;
      mask_q   <= ResetMask;
      locked_q <= 1'b1;
    end else begin
      unique case (state_q)
        StLocked, StUnlocked: begin
          if (key_load_i) begin
            state_q  <= StLoad;
            locked_q <= 1'b1;
            // A bit arriving with key_load is the first bit of the new key.
            if (key_vld_i) begin
              key_q <= key_shift;
              cnt_q <= CntW'(1);
            end else begin
              cnt_q <= '0;
            end
          end
        end
        StLoad: begin
          if (key_load_i) begin
            // Restart the count only; key_q keeps shifting.
            if (key_vld_i) begin
              key_q <= key_shift;
              cnt_q <= CntW'(1);
            end else begin
              cnt_q <= '0;
            end
          end else if (key_vld_i) begin
            key_q <= key_shift;
            if (cnt_q == CntW'(KEY_W - 1)) begin
              cnt_q    <= '0;
              state_q  <= key_match ? StUnlocked : StLocked;
              locked_q <= !key_match;
              mask_q   <= fold_key(key_shift ^ KEY_VALUE);
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        default: begin
          state_q  <= StLocked;
          locked_q <= 1'b1;
        end
      endcase
    end
  end

  assign locked_o = locked_q;

endmodule

// File: tb/tb_sec_corrector_keyed.sv
module tb_sec_corrector_keyed;

  localparam logic [103:0] KV     = 104'hA5C3_0F96_3C5A_E1D2_7B48_96F0_1E;
  // Fold of KV into 32 bits: 4896F01E ^ 5AE1D27B ^ C30F963C ^ 000000A5.
  localparam logic [31:0]  KvFold = 32'hD178_B4FC;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [5:0]  in_chk;
  logic        corr_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_corr;
  logic        out_chk_err;
  logic        out_uncorr;
  logic        key_load;
  logic        key_vld;
  logic        key_bit;
  logic        locked;

  int n_assert;
  int n_fail;

  sec_corrector_keyed dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .in_chk_i     (in_chk),
    .corr_en_i    (corr_en),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_corr_o   (out_corr),
    .out_chk_err_o(out_chk_err),
    .out_uncorr_o (out_uncorr),
    .key_load_i   (key_load),
    .key_vld_i    (key_vld),
    .key_bit_i    (key_bit),
    .locked_o     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Shift nbits of k, MSB first, with key_load on the first bit.
  task automatic shift_key(input logic [103:0] k, input int nbits);
    key_load = 1'b1;
    key_vld  = 1'b1;
    for (int i = 103; i > 103 - nbits; i--) begin
      key_bit = k[i];
      step();
      key_load = 1'b0;
    end
    key_vld = 1'b0;
    key_bit = 1'b0;
  endtask

  // One word in, checked two edges later with out_ready held high.
  task automatic xfer(input string tag, input logic [31:0] d, input logic [5:0] c,
                      input logic ce, input logic [31:0] exp_d, input logic exp_corr,
                      input logic exp_chk, input logic exp_unc);
    out_ready = 1'b1;
    check1({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    in_chk   = c;
    corr_en  = ce;
    step();
    in_valid = 1'b0;
    check1({tag, "_latency"}, out_valid, 1'b0);
    step();
    check1({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, exp_d);
    check1({tag, "_corr"}, out_corr, exp_corr);
    check1({tag, "_chk_err"}, out_chk_err, exp_chk);
    check1({tag, "_uncorr"}, out_uncorr, exp_unc);
  endtask

  initial begin
    int          tx;
    int          rx;
    logic        stalled;
    logic        acc;
    logic [31:0] held;

    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_chk    = '0;
    corr_en   = 1'b1;
    out_ready = 1'b1;
    key_load  = 1'b0;
    key_vld   = 1'b0;
    key_bit   = 1'b0;
    step();
    step();

    // Reset state
    check1("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check1("rst_corr", out_corr, 1'b0);
    check1("rst_chk_err", out_chk_err, 1'b0);
    check1("rst_uncorr", out_uncorr, 1'b0);
    check1("rst_locked", locked, 1'b1);
    check1("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    step();

    // 1: unlock, clean word
    shift_key(KV, 104);
    check1("t1_unlocked", locked, 1'b0);
    xfer("t1_clean", 32'h1, 6'h03, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0);

    // 2: data-bit error at position 3, then check-bit error
    xfer("t2_corr", 32'h1, 6'h00, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    xfer("t2_chkerr", 32'h0, 6'h01, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);

    // 3: syndrome 63 out of range, then the same word bypassed
    xfer("t3_uncorr", 32'h0, 6'h3F, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    xfer("t3_bypass", 32'h0, 6'h3F, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // 4: locked after reset, then a wrong key (LSB flipped gives mask 1)
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check1("t4_locked_rst", locked, 1'b1);
    xfer("t4_masked", 32'h1, 6'h03, 1'b1, 32'h1 ^ KvFold, 1'b0, 1'b0, 1'b0);
    shift_key(KV ^ 104'h1, 104);
    check1("t4_wrong_key", locked, 1'b1);
    xfer("t4_wrong_mask", 32'h1, 6'h03, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);

    // 5: back-pressure with out_ready alternating
    shift_key(KV, 104);
    check1("t5_unlocked", locked, 1'b0);
    tx      = 0;
    rx      = 0;
    stalled = 1'b0;
    held    = '0;
    for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
      if (stalled) begin
        check1("t5_hold_valid", out_valid, 1'b1);
        check("t5_hold_data", out_data, held);
      end
      out_ready = (cyc[0] == 1'b0);
      stalled   = out_valid && !out_ready;
      held      = out_data;
      if (out_valid && out_ready) begin
        check("t5_order", out_data, 32'hA000_0000 + rx);
        rx++;
      end
      in_valid = (tx < 8);
      in_data  = 32'hA000_0000 + tx;
      in_chk   = 6'h00;
      corr_en  = 1'b0;
      acc      = in_valid && in_ready;
      step();
      if (acc) tx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("t5_count", rx, 8);
    step();
    check1("t5_no_dup", out_valid, 1'b0);

    // 6a: reset with two words in flight
    out_ready = 1'b0;
    corr_en   = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h1;
    in_chk    = 6'h03;
    step();
    in_data = 32'h2;
    step();
    in_valid = 1'b0;
    check1("t6_in_flight", out_valid, 1'b1);
    rst = 1'b1;
    step();
    check1("t6_flush_valid", out_valid, 1'b0);
    check1("t6_flush_locked", locked, 1'b1);
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    check1("t6_dropped", out_valid, 1'b0);

    // 6b: reset at bit 50 of a load
    shift_key(KV, 50);
    check1("t6_load_ready", in_ready, 1'b0);
    check1("t6_load_locked", locked, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check1("t6_rst_locked", locked, 1'b1);
    check1("t6_rst_ready", in_ready, 1'b1);
    xfer("t6_key_lost", 32'h1, 6'h03, 1'b1, 32'h1 ^ KvFold, 1'b0, 1'b0, 1'b0);
    shift_key(KV, 104);
    check1("t6_reload", locked, 1'b0);
    xfer("t6_after", 32'h1, 6'h03, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
